dice_roll: RTL

- Input-side controller of the dice display path; seg_spin drives the animation out to the display, this block takes the player's pushbutton in.
- Synchronises and debounces the button, runs a free-running face counter 1..6, and signals "rolling" while the button is held (selects the spin animation).
- On release, after a minimum spin time, latches the face value and presents it with a valid/ack handshake to the display/score logic.

---
 rtl/dice_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 50 +++++
 rtl/dice_roll.sv | 95 +++++++++
 3 files changed

// File: rtl/dice_pkg.sv
// Shared types for the dice datapath: face encoding and roll controller states.
// Used by dice_roll, seg_spin and the score/display logic.
package dice_pkg;

    typedef logic [2:0] face_t;

    localparam face_t FACE_MIN = 3'd1;
    localparam face_t FACE_MAX = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        ROLLING,
        HOLD
    } roll_state_t;

    // Next face in the 1..6 cycle; 0 and 7 are never produced.
    function automatic face_t next_face(input face_t f);
        return (f == FACE_MAX) ? FACE_MIN : f + 3'd1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus level debouncer for an asynchronous pushbutton.
// btn_level only changes after DEBOUNCE_CYCLES consecutive samples that differ
// from it, so the latency from a clean edge is 2 + DEBOUNCE_CYCLES cycles.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_q1;
    logic             btn_sync;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the raw button into the clk domain; only the second flop is used.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always written with <= so every flop
        // samples the pre-edge value of its neighbours, as real flops do.
        if (reset) begin
            sync_q1  <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync_q1  <= btn_raw;
            btn_sync <= sync_q1;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
            btn_level  <= 1'b0;
        end else if (btn_sync != btn_level) begin
            if (stable_cnt == CNT_LAST) begin
                btn_level  <= ~btn_level;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/dice_roll.sv
// Pushbutton side of the dice: debounces the button, spins a 1..6 face
// counter, flags rolling while held and, once released after a minimum spin,
// presents the captured face with a valid/ack handshake.
module dice_roll
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MIN_SPIN_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       roll_ack,
    output logic       rolling,
    output logic       roll_valid,
    output logic [2:0] roll_value,
    output logic       btn_level
);

    localparam int SPIN_W = $clog2(MIN_SPIN_CYCLES + 1);
    localparam logic [SPIN_W-1:0] SPIN_MIN = SPIN_W'(MIN_SPIN_CYCLES);

    roll_state_t       state;
    roll_state_t       state_next;
    logic [SPIN_W-1:0] spin_cnt;
    face_t             face_cnt;
    face_t             value_q;
    logic              capture;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .reset    (reset),
        .btn_raw  (btn_raw),
        .btn_level(btn_level)
    );

    // Free-running face counter, advancing every cycle regardless of state.
    always_ff @(posedge clk) begin
        if (reset) face_cnt <= FACE_MIN;
        else       face_cnt <= next_face(face_cnt);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; capture marks the ROLLING -> HOLD edge.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (btn_level) state_next = ROLLING;
            end
            ROLLING: begin
                if (!btn_level && (spin_cnt >= SPIN_MIN)) begin
                    state_next = HOLD;
                    capture    = 1'b1;
                end
            end
            HOLD: begin
                if (roll_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Spin time in ROLLING, saturating at the minimum; cleared elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            spin_cnt <= '0;
        end else if (state != ROLLING) begin
            spin_cnt <= '0;
        end else if (spin_cnt < SPIN_MIN) begin
            spin_cnt <= spin_cnt + 1'b1;
        end
    end

    // Latch the face on the capture edge and hold it through HOLD.
    always_ff @(posedge clk) begin
        if (reset)        value_q <= FACE_MIN;
        else if (capture) value_q <= face_cnt;
    end

    assign rolling    = (state == ROLLING);
    assign roll_valid = (state == HOLD);
    assign roll_value = value_q;

endmodule
